// File: rtl/sn_window_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : sn_window_counter_if
// Description : Sample/result bundle between a stochastic-bitstream producer
//               and the window counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sn_window_counter_if;
  logic       en;
  logic       sn_valid;
  logic       sn_bit;
  logic [2:0] win_sel;
  logic       res_ready;
  logic       clr_ovr;
  logic       res_valid;
  logic [8:0] res_count;
  logic [9:0] res_bip;
  logic       ovr;
  logic       busy;

  modport master (
    output en, sn_valid, sn_bit, win_sel, res_ready, clr_ovr,
    input  res_valid, res_count, res_bip, ovr, busy
  );

  modport slave (
    input  en, sn_valid, sn_bit, win_sel, res_ready, clr_ovr,
    output res_valid, res_count, res_bip, ovr, busy
  );
endinterface
`default_nettype wire

// File: rtl/sn_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : sn_window_counter
// Description : Counts ones in windows of N = 8 << win_sel valid stochastic
//               bits and offers the count through a valid/ready result reg.
//               Optional bipolar output enabled by macro SN_BIPOLAR_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sn_window_counter #(
  parameter int WSEL_MAX = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sn_window_counter_if.slave   bus
);

  localparam logic [2:0] c_wsel_max = 3'(WSEL_MAX);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_busy;

  logic [2:0] r_wsel;
  logic [8:0] r_samp;
  logic [8:0] r_ones;
  logic       r_res_valid;
  logic [8:0] r_res_count;
  logic       r_ovr;

  logic [2:0] w_wsel_clamp;
  logic [8:0] w_n;
  logic       w_start;
  logic       w_run;
  logic [8:0] w_samp_inc;
  logic [8:0] w_ones_inc;
  logic       w_done;
  logic       w_drop;
  logic       w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.en) w_state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        w_busy = 1'b1;
        if (!bus.en) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wsel_clamp = (bus.win_sel > c_wsel_max) ? c_wsel_max : bus.win_sel;
    w_n          = 9'd8 << r_wsel;
    w_start      = (r_state == ST_IDLE) && bus.en;
    w_run        = (r_state == ST_ACCUM) && bus.en;
    w_samp_inc   = r_samp + 9'd1;
    w_ones_inc   = r_ones + {8'd0, bus.sn_bit};
    w_done       = w_run && bus.sn_valid && (w_samp_inc == w_n);
    // A completed window is only lost when the previous one is still unread.
    w_drop       = w_done && r_res_valid && !bus.res_ready;
    w_load       = w_done && !w_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp      <= 9'd0;
      r_ones      <= 9'd0;
      r_wsel      <= 3'd0;
      r_res_valid <= 1'b0;
      r_res_count <= 9'd0;
      r_ovr       <= 1'b0;
    end else begin
      if (!w_run || w_done) begin
        r_samp <= 9'd0;
        r_ones <= 9'd0;
      end else if (bus.sn_valid) begin
        r_samp <= w_samp_inc;
        r_ones <= w_ones_inc;
      end

      if (w_start || w_done) r_wsel <= w_wsel_clamp;

      if (w_load) begin
        r_res_valid <= 1'b1;
        r_res_count <= w_ones_inc;
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_drop)           r_ovr <= 1'b1;
      else if (bus.clr_ovr) r_ovr <= 1'b0;
    end
  end

`ifdef SN_BIPOLAR_OUT_EN
  logic [9:0] r_res_bip;

  // N is taken from the window that just closed, before r_wsel is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_res_bip <= 10'd0;
    else if (w_load) r_res_bip <= {w_ones_inc, 1'b0} - {1'b0, w_n};
  end

  assign bus.res_bip = r_res_bip;
`else
  assign bus.res_bip = 10'd0;
`endif

  assign bus.res_valid = r_res_valid;
  assign bus.res_count = r_res_count;
  assign bus.ovr       = r_ovr;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: doc/sn_window_counter.md
SN_WINDOW_COUNTER -- requirements
Module: sn_window_counter

Interface
REQ-001 Parameter: WSEL_MAX, default 5, largest legal win_sel code; codes above it behave as WSEL_MAX.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  high = accumulate windows; low = return to IDLE.
REQ-005 sn_valid  input  1  sn_bit is sampled this cycle.
REQ-006 sn_bit  input  1  stochastic bitstream from the multiplier.
REQ-007 win_sel  input  3  window length N = 8 << win_sel (8..256).
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 clr_ovr  input  1  synchronous clear of ovr.
REQ-010 res_valid  output  1  res_count and res_bip hold a completed window.
REQ-011 res_count  output  9  number of ones in the window, 0..N.
REQ-012 res_bip  output  10  signed bipolar value 2*count - N.
REQ-013 ovr  output  1  sticky flag: a completed window was dropped.
REQ-014 busy  output  1  high in ACCUM state.

Function
REQ-015 The FSM SHALL have two states: IDLE and ACCUM; IDLE->ACCUM when en=1, ACCUM->IDLE when en=0 (partial window discarded, counters cleared).
REQ-016 On IDLE->ACCUM and at each window start, win_sel SHALL be latched; changes mid-window take effect at the next window.
REQ-017 In ACCUM each cycle with sn_valid=1 SHALL increment the sample counter and, when sn_bit=1, the ones counter (9-bit, no wrap: max N=256).
REQ-018 Cycles with sn_valid=0 SHALL leave both counters unchanged.
REQ-019 When the sample counter reaches N, the final count including that sample SHALL be offered to the output register on that edge; both counters restart at 0 with no gap cycle.
REQ-020 Latency: res_valid SHALL rise on the clock edge that samples the N-th valid bit.
REQ-021 Handshake: result transfers when res_valid=1 and res_ready=1; res_valid SHALL then fall unless a new window completes in the same cycle, in which case the new result is loaded and res_valid stays 1.
REQ-022 res_count/res_bip SHALL be stable while res_valid=1 and res_ready=0.
REQ-023 If a window completes while res_valid=1 and res_ready=0, the new result SHALL be discarded and ovr set to 1.
REQ-024 ovr SHALL clear on clr_ovr=1 unless a drop occurs the same cycle (set wins).
REQ-025 Going to IDLE SHALL NOT clear a pending res_valid.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counters 0, latched win_sel 0, res_valid 0, res_count 0, res_bip 0, ovr 0, busy 0.
REQ-027 Reset release mid-stream SHALL start a fresh window on the first en=1 cycle.

Configuration
REQ-028 Macro SN_BIPOLAR_OUT_EN: defined -> res_bip = 2*res_count - N (N latched with the result), registered with res_count.
REQ-029 Not defined -> res_bip SHALL be constant 0 and no bipolar logic synthesised.

Verification
REQ-030 win_sel=0, en=1, 8 valid bits 1,1,0,1,0,0,1,1, res_ready=1 -> res_valid one cycle, res_count=5, res_bip=2 (macro on).
REQ-031 win_sel=5, 256 valid ones -> res_count=256, res_bip=256; all zeros -> 0, -256.
REQ-032 win_sel=0, res_ready=0, 16 valid bits -> first result held unchanged, ovr=1 after bit 16; clr_ovr=1 -> ovr=0.
REQ-033 win_sel=0, sn_valid toggled every other cycle, 8 ones -> result after 16 cycles, count=8; back-to-back windows with res_ready=1 on completion cycle -> res_valid stays 1, second count loaded.
REQ-034 Assert rst_n=0 after 5 bits, release, run 8 ones -> all outputs 0 during reset, next result count=8; en=0 mid-window -> partial discarded.
